dmem_apb_slave: RTL and testbench

// - APB completer for data memory: the responder at the far end of the execute stage's dmem_apb master port.
// - Holds a word-organised RAM and serves single APB reads and writes.
// - Supports byte/half stores via PSTRB, a programmable number of wait states, and PSLVERR for bad addresses.
// - Sits between the core's dmem APB bus and the on-chip data SRAM.

---
 rtl/dmem_apb_slave.sv | 169 ++++++++++++++++
 tb/tb_dmem_apb_slave.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_apb_slave.sv
// APB completer for the core's data memory: word-organised RAM with byte strobes,
// a fixed number of wait states and PSLVERR on misaligned or out-of-range addresses.
module dmem_apb_slave #(
  parameter int unsigned       DAT_W       = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [ADDR_W-1:0]    paddr_i,
  input  logic [DAT_W-1:0]     pwdata_i,
  input  logic [DAT_W/8-1:0]   pstrb_i,
  output logic [DAT_W-1:0]     prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o
);

  localparam int unsigned STRB_W = DAT_W / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  // One bit wider than the bus so a window ending at the top of the map does not wrap.
  localparam logic [ADDR_W:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDR_W+1)'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;

  logic [IDX_W-1:0]   idx_q;
  logic               write_q;
  logic               err_q;
  logic [DAT_W-1:0]   wdata_q;
  logic [STRB_W-1:0]  strb_q;

  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic [DAT_W-1:0]   prdata_q, prdata_d;

  logic [DAT_W-1:0]   mem [DEPTH_WORDS];

  logic               setup;
  logic               accept;
  logic               addr_err;
  logic [ADDR_W-1:0]  offset;
  logic [IDX_W-1:0]   idx_in;
  logic               cur_write;
  logic               cur_err;
  logic [IDX_W-1:0]   cur_idx;
  logic               mem_we;

  assign setup    = psel_i & ~penable_i;
  assign accept   = (state_q == StIdle) & setup;
  assign offset   = paddr_i - BASE_ADDR;
  assign idx_in   = IDX_W'(offset >> 2);
  assign addr_err = (paddr_i[1:0] != 2'b00)
                  | ({1'b0, paddr_i} < {1'b0, BASE_ADDR})
                  | ({1'b0, paddr_i} >= END_ADDR);

  // With zero wait states RESP is entered straight from the setup cycle, before the
  // request registers are loaded, so the response is built from the live bus.
  assign cur_write = accept ? pwrite_i : write_q;
  assign cur_err   = accept ? addr_err : err_q;
  assign cur_idx   = accept ? idx_in   : idx_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (setup) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (!psel_i) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: outputs are registered, so they are computed from the state being entered.
  always_comb begin
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    if (state_d == StResp) begin
      pready_d  = 1'b1;
      pslverr_d = cur_err;
      if (!cur_write) begin
        prdata_d = cur_err ? '0 : mem[cur_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Request capture: address and data are sampled only in the setup cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (accept) begin
      idx_q   <= idx_in;
      write_q <= pwrite_i;
      err_q   <= addr_err;
      wdata_q <= pwdata_i;
      strb_q  <= pstrb_i;
    end
  end

  // Commit at the end of RESP, only if the master is still selecting us.
  assign mem_we = (state_q == StResp) & psel_i & write_q & ~err_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign prdata_o  = prdata_q;

endmodule

// File: tb/tb_dmem_apb_slave.sv
// Randomized self-checking bench for dmem_apb_slave: two instances (no wait states at
// base 0, three wait states at a non-zero base) checked against a word-array memory model.
module tb_dmem_apb_slave;

  localparam int unsigned Depth = 64;
  localparam int unsigned Ws0   = 0;
  localparam int unsigned Ws1   = 3;
  localparam logic [31:0] Base0 = 32'h0000_0000;
  localparam logic [31:0] Base1 = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  logic [31:0] model [2][Depth];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  dmem_apb_slave #(
    .DAT_W(32), .ADDR_W(32), .DEPTH_WORDS(Depth), .BASE_ADDR(Base0), .WAIT_STATES(Ws0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .psel_i(psel[0]), .penable_i(penable[0]), .pwrite_i(pwrite[0]),
    .paddr_i(paddr[0]), .pwdata_i(pwdata[0]), .pstrb_i(pstrb[0]), .prdata_o(prdata[0]),
    .pready_o(pready[0]), .pslverr_o(pslverr[0])
  );

  dmem_apb_slave #(
    .DAT_W(32), .ADDR_W(32), .DEPTH_WORDS(Depth), .BASE_ADDR(Base1), .WAIT_STATES(Ws1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .psel_i(psel[1]), .penable_i(penable[1]), .pwrite_i(pwrite[1]),
    .paddr_i(paddr[1]), .pwdata_i(pwdata[1]), .pstrb_i(pstrb[1]), .prdata_o(prdata[1]),
    .pready_o(pready[1]), .pslverr_o(pslverr[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? Base0 : Base1;
  endfunction

  function automatic int unsigned ws_of(input int d);
    return (d == 0) ? Ws0 : Ws1;
  endfunction

  function automatic bit exp_err(input int d, input logic [31:0] a);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base_of(d)};
    hi = lo + 33'(4 * Depth);
    return (a[1:0] != 2'b00) || ({1'b0, a} < lo) || ({1'b0, a} >= hi);
  endfunction

  // Full APB transfer; entered and left at 1 time unit after a rising edge so calls chain
  // back-to-back with the next setup in the cycle right after RESP.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd);
    int          lat;
    int          idx;
    bit          e;
    logic [31:0] exp;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    paddr[d] = $urandom; pwdata[d] = $urandom; pstrb[d] = 4'($urandom);
    lat = 1;
    while (pready[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    e = exp_err(d, a);
    check_eq("latency", 32'(lat), 32'(ws_of(d) + 1));
    check_eq("pslverr", 32'(pslverr[d]), 32'(e));
    rd = prdata[d];
    idx = e ? 0 : int'((a - base_of(d)) >> 2);
    if (!wr) begin
      exp = e ? 32'h0 : model[d][idx];
      check_eq("prdata", prdata[d], exp);
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    check_eq("pready_pulse", 32'(pready[d]), 32'h0);
    if (wr && !e) begin
      for (int i = 0; i < 4; i++) begin
        if (st[i]) model[d][idx][8*i +: 8] = wd[8*i +: 8];
      end
    end
  endtask

  task automatic run_random(input int d, input int n);
    int          k;
    logic [31:0] a;
    logic [31:0] rd;
    for (int j = 0; j < n; j++) begin
      k = int'($urandom_range(0, 9));
      a = base_of(d) + 4 * $urandom_range(0, Depth - 1);
      if (k == 0) a = a | $urandom_range(1, 3);
      else if (k == 1) a = base_of(d) + 32'(4 * Depth) + 4 * $urandom_range(0, 15);
      else if (k == 2 && d == 1) a = base_of(d) - 4 * $urandom_range(1, 16);
      xfer(d, 1'($urandom), a, $urandom, 4'($urandom), rd);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] old;
    int          seen;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_pready", 32'(pready[d]), 32'h0);
      check_eq("rst_pslverr", 32'(pslverr[d]), 32'h0);
      check_eq("rst_prdata", prdata[d], 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill both memories so every later read has a defined expectation.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < Depth; i++) begin
        xfer(d, 1'b1, base_of(d) + 32'(4 * i), $urandom, 4'hF, rd);
      end
    end

    // Full write then immediate read, then byte-lane merges.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    check_eq("deadbeef", rd, 32'hDEADBEEF);
    xfer(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd);
    xfer(0, 1'b1, 32'h10, 32'h00BB0000, 4'b0100, rd);
    xfer(0, 1'b1, 32'h10, 32'h11111111, 4'b0000, rd);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    check_eq("lane_merge", rd, 32'hDEBBBEAA);

    // Error responses and an untouched last word.
    xfer(0, 1'b0, 32'h2, 32'h0, 4'h0, rd);
    check_eq("misaligned_rdata", rd, 32'h0);
    xfer(0, 1'b1, Base0 + 32'(4 * Depth), 32'h5A5A5A5A, 4'hF, rd);
    xfer(0, 1'b0, Base0 + 32'(4 * (Depth - 1)), 32'h0, 4'h0, rd);
    xfer(1, 1'b0, Base1 + 32'h20, 32'h0, 4'h0, rd);
    xfer(1, 1'b1, Base1 - 32'h4, 32'h5A5A5A5A, 4'hF, rd);
    xfer(1, 1'b0, Base1, 32'h0, 4'h0, rd);

    // Access phase with no setup must be ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 32'h10;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (pready[0] === 1'b1) seen++;
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    check_eq("idle_penable", 32'(seen), 32'h0);

    // Master drops PSEL in the first wait cycle of a write.
    old = model[1][12];
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = Base1 + 32'h30; pwdata[1] = ~old; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    seen = 0;
    repeat (6) begin
      if (pready[1] === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check_eq("drop_no_ready", 32'(seen), 32'h0);
    xfer(1, 1'b0, Base1 + 32'h30, 32'h0, 4'h0, rd);
    check_eq("drop_old", rd, old);
    xfer(1, 1'b1, Base1 + 32'h30, 32'hCAFEF00D, 4'hF, rd);
    xfer(1, 1'b0, Base1 + 32'h30, 32'h0, 4'h0, rd);
    check_eq("drop_recover", rd, 32'hCAFEF00D);

    // Asynchronous reset in the middle of a write's wait states.
    xfer(1, 1'b1, Base1 + 32'h40, 32'h12345678, 4'hF, rd);
    xfer(1, 1'b0, Base1 + 32'h40, 32'h0, 4'h0, rd);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = Base1 + 32'h40; pwdata[1] = 32'hFFFF0000; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_pready", 32'(pready[1]), 32'h0);
    check_eq("arst_pslverr", 32'(pslverr[1]), 32'h0);
    check_eq("arst_prdata", prdata[1], 32'h0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b0, Base1 + 32'h40, 32'h0, 4'h0, rd);
    check_eq("arst_ram_kept", rd, 32'h12345678);

    run_random(0, 150);
    run_random(1, 150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
